// File: rtl/controle_escrita_banco.sv
// Register-bank write-port owner: round-robin writeback arbiter,
// one-cycle registered write stage and a pending-write scoreboard.
module controle_escrita_banco #(
  parameter int LARGURA     = 32,
  parameter int LARGURA_END = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valido_a,
  input  logic [LARGURA_END-1:0]   destino_a,
  input  logic [LARGURA-1:0]       dado_a,
  output logic                     pronto_a,
  input  logic                     valido_b,
  input  logic [LARGURA_END-1:0]   destino_b,
  input  logic [LARGURA-1:0]       dado_b,
  output logic                     pronto_b,
  input  logic                     reserva,
  input  logic [LARGURA_END-1:0]   reserva_reg,
  output logic                     escrita,
  output logic [LARGURA_END-1:0]   destino,
  output logic [LARGURA-1:0]       dado_entrada,
  output logic [(1<<LARGURA_END)-1:0] pendente
);

  localparam int NREG = 1 << LARGURA_END;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } fonte_t;

  fonte_t ultimo_q;
  fonte_t ultimo_d;

  logic                   xfer;
  logic [LARGURA_END-1:0] sel_dest;
  logic [LARGURA-1:0]     sel_dado;
  logic [NREG-1:0]        pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ultimo_q <= SRC_B;
    end else begin
      ultimo_q <= ultimo_d;
    end
  end

  // The loser of a contention keeps its request, so it wins next time.
  always_comb begin
    pronto_a = 1'b0;
    pronto_b = 1'b0;
    ultimo_d = ultimo_q;
    sel_dest = destino_a;
    sel_dado = dado_a;
    unique case (1'b1)
      (valido_a && valido_b): begin
        if (ultimo_q == SRC_B) begin
          pronto_a = 1'b1;
        end else begin
          pronto_b = 1'b1;
        end
      end
      (valido_a && !valido_b): pronto_a = 1'b1;
      (!valido_a && valido_b): pronto_b = 1'b1;
      default: ;
    endcase
    if (pronto_a) begin
      ultimo_d = SRC_A;
    end else if (pronto_b) begin
      ultimo_d = SRC_B;
      sel_dest = destino_b;
      sel_dado = dado_b;
    end
  end

  assign xfer = pronto_a | pronto_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      escrita      <= 1'b0;
      destino      <= '0;
      dado_entrada <= '0;
    end else if (xfer) begin
      escrita      <= (sel_dest != '0);
      destino      <= sel_dest;
      dado_entrada <= sel_dado;
    end else begin
      escrita      <= 1'b0;
    end
  end

  // A new reservation beats the commit of an older producer.
  always_comb begin
    pend_d = pendente;
    for (int i = 1; i < NREG; i++) begin
      if (reserva && reserva_reg == LARGURA_END'(i)) begin
        pend_d[i] = 1'b1;
      end else if (escrita && destino == LARGURA_END'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendente <= '0;
    end else begin
      pendente <= pend_d;
    end
  end

endmodule

// File: tb/tb_controle_escrita_banco.sv
// Scoreboard bench for controle_escrita_banco:
// directed writebacks, arbitration, r0 drop, pending bits, async reset.
module tb_controle_escrita_banco;

  logic        clk;
  logic        rst_n;
  logic        valido_a;
  logic [4:0]  destino_a;
  logic [31:0] dado_a;
  logic        pronto_a;
  logic        valido_b;
  logic [4:0]  destino_b;
  logic [31:0] dado_b;
  logic        pronto_b;
  logic        reserva;
  logic [4:0]  reserva_reg;
  logic        escrita;
  logic [4:0]  destino;
  logic [31:0] dado_entrada;
  logic [31:0] pendente;

  int checks;
  int errors;
  logic [36:0] fila[$];

  controle_escrita_banco #(
    .LARGURA(32),
    .LARGURA_END(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valido_a(valido_a),
    .destino_a(destino_a),
    .dado_a(dado_a),
    .pronto_a(pronto_a),
    .valido_b(valido_b),
    .destino_b(destino_b),
    .dado_b(dado_b),
    .pronto_b(pronto_b),
    .reserva(reserva),
    .reserva_reg(reserva_reg),
    .escrita(escrita),
    .destino(destino),
    .dado_entrada(dado_entrada),
    .pendente(pendente)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && escrita === 1'b1) begin
      logic [36:0] e;
      if (fila.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got d%0d %h expected none",
                 destino, dado_entrada);
      end else begin
        e = fila.pop_front();
        chk("wr_destino", 32'(destino), 32'(e[36:32]));
        chk("wr_dado", dado_entrada, e[31:0]);
      end
    end
  end

  task automatic cyc(input string nm,
                     input logic va, input logic [4:0] xa,
                     input logic [31:0] da,
                     input logic vb, input logic [4:0] xb,
                     input logic [31:0] db,
                     input logic rv, input logic [4:0] rr,
                     input logic epa, input logic epb);
    valido_a = va; destino_a = xa; dado_a = da;
    valido_b = vb; destino_b = xb; dado_b = db;
    reserva = rv; reserva_reg = rr;
    #1;
    chk({nm, "_pronto_a"}, 32'(pronto_a), 32'(epa));
    chk({nm, "_pronto_b"}, 32'(pronto_b), 32'(epb));
    if (epa && xa != 5'd0) fila.push_back({xa, da});
    if (epb && xb != 5'd0) fila.push_back({xb, db});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    valido_a = 0; destino_a = 0; dado_a = 0;
    valido_b = 0; destino_b = 0; dado_b = 0;
    reserva = 0; reserva_reg = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_escrita", 32'(escrita), 0);
    chk("rst_destino", 32'(destino), 0);
    chk("rst_dado", dado_entrada, 0);
    chk("rst_pendente", pendente, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cyc("t1", 1, 3, 32'hA5A5_0003, 0, 0, 0, 0, 0, 1, 0);
    chk("t1_escrita", 32'(escrita), 1);
    idle("t1_idle");
    chk("t1_escrita_off", 32'(escrita), 0);

    cyc("t3", 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1);
    chk("t3_escrita", 32'(escrita), 0);
    chk("t3_pendente", pendente, 0);

    cyc("t2c1", 1, 4, 32'h4444_0001, 1, 5, 32'h5555_0001,
        0, 0, 1, 0);
    chk("t2c1_escrita", 32'(escrita), 1);
    cyc("t2c2", 1, 4, 32'h4444_0002, 1, 5, 32'h5555_0001,
        0, 0, 0, 1);
    chk("t2c2_escrita", 32'(escrita), 1);
    cyc("t2c3", 1, 4, 32'h4444_0002, 1, 5, 32'h5555_0002,
        0, 0, 1, 0);
    chk("t2c3_escrita", 32'(escrita), 1);
    cyc("t2c4", 1, 4, 32'h4444_0003, 1, 5, 32'h5555_0002,
        0, 0, 0, 1);
    chk("t2c4_escrita", 32'(escrita), 1);
    idle("t2_idle");

    cyc("t4r", 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    chk("t4_pend_set", pendente, 32'h0000_0080);
    cyc("t4w", 1, 7, 32'h7777_0007, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_pend_hold", pendente, 32'h0000_0080);
    chk("t4_destino", 32'(destino), 7);
    idle("t4_idle");
    chk("t4_pend_clr", pendente, 0);

    cyc("t5r", 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    cyc("t5w", 1, 9, 32'h9999_0009, 0, 0, 0, 0, 0, 1, 0);
    chk("t5_destino", 32'(destino), 9);
    cyc("t5rr", 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    chk("t5_pend_keep", pendente, 32'h0000_0200);
    idle("t5_idle");
    chk("t5_pend_still", pendente, 32'h0000_0200);

    valido_a = 1; destino_a = 10; dado_a = 32'hAAAA_000A;
    reserva = 1; reserva_reg = 11;
    #1;
    chk("t6_pronto_a", 32'(pronto_a), 1);
    @(posedge clk);
    #1;
    valido_a = 0; reserva = 0;
    chk("t6_pre_escrita", 32'(escrita), 1);
    chk("t6_pre_pend", pendente, 32'h0000_0A00);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_escrita", 32'(escrita), 0);
    chk("t6_destino", 32'(destino), 0);
    chk("t6_dado", dado_entrada, 0);
    chk("t6_pendente", pendente, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("t6c", 1, 12, 32'hCCCC_000C, 1, 13, 32'hDDDD_000D,
        0, 0, 1, 0);
    chk("t6c_destino", 32'(destino), 12);
    idle("t6_idle1");
    idle("t6_idle2");

    chk("fila_vazia", 32'(fila.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
